// File: rtl/prog_fsm_engine_if.sv
// Control/status bundle of the programmable FSM engine: run controls, config
// write port and the observed state/output vector.
interface prog_fsm_engine_if #(
    parameter int N_STATES = 8,
    parameter int N_IN     = 3,
    parameter int N_OUT    = 2,
    parameter int N_SLOTS  = 4
);
    localparam int SW = ($clog2(N_STATES) > 1) ? $clog2(N_STATES) : 1;
    localparam int KW = ($clog2(N_SLOTS) > 1) ? $clog2(N_SLOTS) : 1;

    logic             en;
    logic             restart;
    logic [N_IN-1:0]  in;
    logic             cfg_rule_we;
    logic             cfg_moore_we;
    logic [SW-1:0]    cfg_state;
    logic [KW-1:0]    cfg_slot;
    logic             cfg_valid;
    logic [N_IN-1:0]  cfg_care;
    logic [N_IN-1:0]  cfg_match;
    logic [SW-1:0]    cfg_next;
    logic [N_OUT-1:0] cfg_omask;
    logic [N_OUT-1:0] cfg_oval;
    logic [SW-1:0]    state;
    logic [N_OUT-1:0] out;
    logic             hit;
    logic [KW-1:0]    hit_slot;
    logic             cfg_err;

    modport master (
        output en, restart, in, cfg_rule_we, cfg_moore_we, cfg_state, cfg_slot,
               cfg_valid, cfg_care, cfg_match, cfg_next, cfg_omask, cfg_oval,
        input  state, out, hit, hit_slot, cfg_err
    );

    modport slave (
        input  en, restart, in, cfg_rule_we, cfg_moore_we, cfg_state, cfg_slot,
               cfg_valid, cfg_care, cfg_match, cfg_next, cfg_omask, cfg_oval,
        output state, out, hit, hit_slot, cfg_err
    );
endinterface

// File: rtl/prog_fsm_engine.sv
// Table-driven FSM: per-state prioritised match rules pick the next state and
// optional Mealy bit overrides on top of a per-state Moore output.
module prog_fsm_engine #(
    parameter int N_STATES   = 8,
    parameter int N_IN       = 3,
    parameter int N_OUT      = 2,
    parameter int N_SLOTS    = 4,
    parameter int INIT_STATE = 0
) (
    input logic              clock,
    input logic              reset_L,
    prog_fsm_engine_if.slave bus
);
    localparam int SW = ($clog2(N_STATES) > 1) ? $clog2(N_STATES) : 1;
    localparam int KW = ($clog2(N_SLOTS) > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [SW:0]   STATES_W = (SW+1)'(N_STATES);
    localparam logic [KW:0]   SLOTS_W  = (KW+1)'(N_SLOTS);
    localparam logic [SW-1:0] INIT_W   = SW'(INIT_STATE);

    logic             valid_q [N_STATES][N_SLOTS];
    logic [N_IN-1:0]  care_q  [N_STATES][N_SLOTS];
    logic [N_IN-1:0]  match_q [N_STATES][N_SLOTS];
    logic [SW-1:0]    next_q  [N_STATES][N_SLOTS];
    logic [N_OUT-1:0] omask_q [N_STATES][N_SLOTS];
    logic [N_OUT-1:0] oval_q  [N_STATES][N_SLOTS];
    logic [N_OUT-1:0] moore_q [N_STATES];

    logic [SW-1:0]    state_q, state_d;
    logic             cfg_err_q, cfg_err_d;

    logic             state_ok_s, hit_s, take_s, next_bad_s;
    logic             wr_state_bad_s, wr_slot_bad_s, rule_ok_s, moore_ok_s;
    logic [KW-1:0]    slot_s;
    logic [SW-1:0]    win_next_s;
    logic [N_OUT-1:0] win_omask_s, win_oval_s, moore_s, out_s;

    function automatic logic rule_match(input logic v, input logic [N_IN-1:0] in_v,
                                        input logic [N_IN-1:0] care, input logic [N_IN-1:0] match);
        return v && (((in_v ^ match) & care) == {N_IN{1'b0}});
    endfunction

    assign state_ok_s     = ({1'b0, state_q} < STATES_W);
    assign wr_state_bad_s = ({1'b0, bus.cfg_state} >= STATES_W);
    assign wr_slot_bad_s  = ({1'b0, bus.cfg_slot} >= SLOTS_W);
    assign rule_ok_s      = bus.cfg_rule_we && !wr_state_bad_s && !wr_slot_bad_s;
    assign moore_ok_s     = bus.cfg_moore_we && !wr_state_bad_s;

    // Rule lookup: scan high to low so the lowest matching slot is left standing.
    always_comb begin
        hit_s       = 1'b0;
        slot_s      = {KW{1'b0}};
        win_next_s  = {SW{1'b0}};
        win_omask_s = {N_OUT{1'b0}};
        win_oval_s  = {N_OUT{1'b0}};
        moore_s     = {N_OUT{1'b0}};
        if (state_ok_s) begin
            moore_s = moore_q[state_q];
            for (int k = N_SLOTS - 1; k >= 0; k--) begin
                if (rule_match(valid_q[state_q][k], bus.in, care_q[state_q][k], match_q[state_q][k])) begin
                    hit_s       = 1'b1;
                    slot_s      = KW'(k);
                    win_next_s  = next_q[state_q][k];
                    win_omask_s = omask_q[state_q][k];
                    win_oval_s  = oval_q[state_q][k];
                end else begin
                    hit_s = hit_s;
                end
            end
        end else begin
            moore_s = {N_OUT{1'b0}};
        end
    end

    assign take_s     = bus.en && hit_s && !bus.restart;
    assign next_bad_s = ({1'b0, win_next_s} >= STATES_W);

    // Output merge, next-state selection and config error detection.
    always_comb begin
        out_s     = moore_s;
        state_d   = state_q;
        cfg_err_d = (bus.cfg_rule_we && (wr_state_bad_s || wr_slot_bad_s))
                  || (bus.cfg_moore_we && wr_state_bad_s)
                  || (take_s && next_bad_s);
        if (bus.en && hit_s) begin
            out_s = (moore_s & ~win_omask_s) | (win_oval_s & win_omask_s);
        end else begin
            out_s = moore_s;
        end
        if (bus.restart) begin
            state_d = INIT_W;
        end else if (take_s) begin
            state_d = next_bad_s ? INIT_W : win_next_s;
        end else begin
            state_d = state_q;
        end
    end

    // State register and registered error pulse.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q   <= INIT_W;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Transition table and Moore entries; cleared by reset, written through cfg.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            for (int s = 0; s < N_STATES; s++) begin
                moore_q[s] <= {N_OUT{1'b0}};
                for (int k = 0; k < N_SLOTS; k++) begin
                    valid_q[s][k] <= 1'b0;
                    care_q[s][k]  <= {N_IN{1'b0}};
                    match_q[s][k] <= {N_IN{1'b0}};
                    next_q[s][k]  <= {SW{1'b0}};
                    omask_q[s][k] <= {N_OUT{1'b0}};
                    oval_q[s][k]  <= {N_OUT{1'b0}};
                end
            end
        end else begin
            if (rule_ok_s) begin
                valid_q[bus.cfg_state][bus.cfg_slot] <= bus.cfg_valid;
                care_q[bus.cfg_state][bus.cfg_slot]  <= bus.cfg_care;
                match_q[bus.cfg_state][bus.cfg_slot] <= bus.cfg_match;
                next_q[bus.cfg_state][bus.cfg_slot]  <= bus.cfg_next;
                omask_q[bus.cfg_state][bus.cfg_slot] <= bus.cfg_omask;
                oval_q[bus.cfg_state][bus.cfg_slot]  <= bus.cfg_oval;
            end
            if (moore_ok_s) begin
                moore_q[bus.cfg_state] <= bus.cfg_oval;
            end
        end
    end

    assign bus.state    = state_q;
    assign bus.out      = out_s;
    assign bus.hit      = hit_s;
    assign bus.hit_slot = slot_s;
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_prog_fsm_engine.sv
// Bench for prog_fsm_engine (6 states so out-of-range writes are reachable):
// directed plan with literal checks, then random traffic against a table model.
module tb_prog_fsm_engine;
    localparam int NS = 6, NI = 3, NO = 2, NK = 4, INIT = 0, SW = 3, KW = 2;

    logic clock, reset_L;
    int   n_chk = 0, n_fail = 0;

    prog_fsm_engine_if #(.N_STATES(NS), .N_IN(NI), .N_OUT(NO), .N_SLOTS(NK)) bus ();
    prog_fsm_engine #(.N_STATES(NS), .N_IN(NI), .N_OUT(NO), .N_SLOTS(NK), .INIT_STATE(INIT))
        dut (.clock(clock), .reset_L(reset_L), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain table of rules, looked up first-match in slot order.
    bit          m_valid [NS][NK];
    logic [NI-1:0] m_care [NS][NK];
    logic [NI-1:0] m_match[NS][NK];
    int          m_next  [NS][NK];
    logic [NO-1:0] m_omask[NS][NK];
    logic [NO-1:0] m_oval [NS][NK];
    logic [NO-1:0] m_moore[NS];
    int          m_state;
    bit          m_err;
    bit          model_ok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_eval(output bit h, output int slot, output logic [NO-1:0] o);
        h = 1'b0;
        slot = 0;
        for (int s = 0; s < NK; s++) begin
            if (!h && m_valid[m_state][s] &&
                (((bus.in ^ m_match[m_state][s]) & m_care[m_state][s]) == 3'b000)) begin
                h = 1'b1;
                slot = s;
            end
        end
        o = m_moore[m_state];
        if (bus.en && h) begin
            for (int b = 0; b < NO; b++)
                if (m_omask[m_state][slot][b]) o[b] = m_oval[m_state][slot][b];
        end
    endfunction

    always @(posedge clock) begin
        bit h; int sl; logic [NO-1:0] o; bit e;
        if (!reset_L) begin
            for (int s = 0; s < NS; s++) begin
                m_moore[s] = 2'b00;
                for (int k = 0; k < NK; k++) begin
                    m_valid[s][k] = 1'b0; m_care[s][k] = 3'b000; m_match[s][k] = 3'b000;
                    m_next[s][k] = 0; m_omask[s][k] = 2'b00; m_oval[s][k] = 2'b00;
                end
            end
            m_state = INIT;
            m_err = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            model_eval(h, sl, o);
            e = 1'b0;
            if (bus.restart) m_state = INIT;
            else if (bus.en && h) begin
                if (m_next[m_state][sl] >= NS) begin
                    m_state = INIT;
                    e = 1'b1;
                end else m_state = m_next[m_state][sl];
            end
            if (bus.cfg_rule_we) begin
                if (int'(bus.cfg_state) >= NS || int'(bus.cfg_slot) >= NK) e = 1'b1;
                else begin
                    m_valid[bus.cfg_state][bus.cfg_slot] = bus.cfg_valid;
                    m_care[bus.cfg_state][bus.cfg_slot]  = bus.cfg_care;
                    m_match[bus.cfg_state][bus.cfg_slot] = bus.cfg_match;
                    m_next[bus.cfg_state][bus.cfg_slot]  = int'(bus.cfg_next);
                    m_omask[bus.cfg_state][bus.cfg_slot] = bus.cfg_omask;
                    m_oval[bus.cfg_state][bus.cfg_slot]  = bus.cfg_oval;
                end
            end
            if (bus.cfg_moore_we) begin
                if (int'(bus.cfg_state) >= NS) e = 1'b1;
                else m_moore[bus.cfg_state] = bus.cfg_oval;
            end
            m_err = e;
        end
    end

    // Per-cycle comparison, sampled mid low phase after inputs have settled.
    always @(negedge clock) begin
        bit h; int sl; logic [NO-1:0] o;
        #2;
        if (model_ok) begin
            model_eval(h, sl, o);
            chk("state", bus.state, m_state);
            chk("out", bus.out, o);
            chk("hit", bus.hit, h);
            chk("hit_slot", bus.hit_slot, h ? sl : 0);
            chk("cfg_err", bus.cfg_err, m_err);
        end
    end

    task automatic set_idle();
        reset_L = 1'b1;
        bus.en = 1'b0; bus.restart = 1'b0; bus.in = 3'b000;
        bus.cfg_rule_we = 1'b0; bus.cfg_moore_we = 1'b0;
        bus.cfg_state = 3'd0; bus.cfg_slot = 2'd0; bus.cfg_valid = 1'b0;
        bus.cfg_care = 3'b000; bus.cfg_match = 3'b000; bus.cfg_next = 3'd0;
        bus.cfg_omask = 2'b00; bus.cfg_oval = 2'b00;
    endtask

    task automatic cycle(input bit en_v, input bit rs_v, input logic [NI-1:0] in_v);
        @(negedge clock);
        set_idle();
        bus.en = en_v; bus.restart = rs_v; bus.in = in_v;
        #3;
    endtask

    task automatic wr_rule(input int st, input int sl, input bit v, input logic [NI-1:0] care,
                           input logic [NI-1:0] match, input int nxt, input logic [NO-1:0] om,
                           input logic [NO-1:0] ov, input bit en_v, input logic [NI-1:0] in_v);
        @(negedge clock);
        set_idle();
        bus.cfg_rule_we = 1'b1;
        bus.cfg_state = SW'(st); bus.cfg_slot = KW'(sl); bus.cfg_valid = v;
        bus.cfg_care = care; bus.cfg_match = match; bus.cfg_next = SW'(nxt);
        bus.cfg_omask = om; bus.cfg_oval = ov;
        bus.en = en_v; bus.in = in_v;
        #3;
    endtask

    task automatic wr_moore(input int st, input logic [NO-1:0] val);
        @(negedge clock);
        set_idle();
        bus.cfg_moore_we = 1'b1; bus.cfg_state = SW'(st); bus.cfg_oval = val;
        #3;
    endtask

    initial begin
        set_idle();
        reset_L = 1'b0;
        @(negedge clock);
        // Reset state
        cycle(1'b0, 1'b0, 3'b000);
        chk("rst_state", bus.state, 0); chk("rst_out", bus.out, 2'b00);
        chk("rst_hit", bus.hit, 0); chk("rst_err", bus.cfg_err, 0);
        // Basic matching
        wr_rule(0, 0, 1'b1, 3'b011, 3'b011, 1, 2'b00, 2'b00, 1'b0, 3'b000);
        wr_rule(0, 1, 1'b1, 3'b011, 3'b001, 2, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b1, 1'b0, 3'b011);
        chk("m0_hit", bus.hit, 1); chk("m0_slot", bus.hit_slot, 0);
        cycle(1'b0, 1'b1, 3'b000);
        chk("m0_next", bus.state, 1);
        cycle(1'b1, 1'b0, 3'b001);
        chk("m1_slot", bus.hit_slot, 1);
        cycle(1'b0, 1'b0, 3'b000);
        chk("m1_next", bus.state, 2);
        // Priority among unconditional rules
        wr_rule(0, 0, 1'b1, 3'b000, 3'b000, 3, 2'b00, 2'b00, 1'b0, 3'b000);
        wr_rule(0, 2, 1'b1, 3'b000, 3'b000, 5, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b000);
        cycle(1'b1, 1'b0, 3'b110);
        chk("pri_slot", bus.hit_slot, 0);
        cycle(1'b0, 1'b1, 3'b000);
        chk("pri_next", bus.state, 3);
        wr_rule(0, 0, 1'b0, 3'b000, 3'b000, 3, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b1, 1'b0, 3'b010);
        chk("pri2_slot", bus.hit_slot, 2);
        cycle(1'b0, 1'b1, 3'b000);
        chk("pri2_next", bus.state, 5);
        // Moore output with Mealy override
        wr_moore(1, 2'b10);
        wr_rule(1, 0, 1'b1, 3'b111, 3'b100, 1, 2'b01, 2'b01, 1'b0, 3'b000);
        wr_rule(0, 0, 1'b1, 3'b011, 3'b011, 1, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b1, 1'b0, 3'b011);
        cycle(1'b1, 1'b0, 3'b100);
        chk("mealy_state", bus.state, 1); chk("mealy_out", bus.out, 2'b11);
        cycle(1'b1, 1'b0, 3'b000);
        chk("moore_out", bus.out, 2'b10); chk("moore_hit", bus.hit, 0);
        cycle(1'b0, 1'b0, 3'b100);
        chk("en0_out", bus.out, 2'b10);
        cycle(1'b0, 1'b0, 3'b000);
        chk("en0_state", bus.state, 1);
        // Out-of-range writes
        wr_rule(7, 0, 1'b1, 3'b000, 3'b000, 4, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b0, 1'b0, 3'b000);
        chk("oob_err", bus.cfg_err, 1);
        cycle(1'b0, 1'b0, 3'b000);
        chk("oob_err_clr", bus.cfg_err, 0);
        wr_moore(6, 2'b11);
        cycle(1'b0, 1'b0, 3'b000);
        chk("oob_moore_err", bus.cfg_err, 1);
        // Restart beats a hit; override still visible
        cycle(1'b1, 1'b1, 3'b100);
        chk("rs_out", bus.out, 2'b11); chk("rs_hit", bus.hit, 1);
        cycle(1'b0, 1'b0, 3'b000);
        chk("rs_state", bus.state, 0);
        // Rule rewritten in the cycle it matches uses the old entry
        wr_rule(0, 0, 1'b1, 3'b011, 3'b011, 4, 2'b00, 2'b00, 1'b1, 3'b011);
        cycle(1'b0, 1'b1, 3'b000);
        chk("wr_old", bus.state, 1);
        cycle(1'b1, 1'b0, 3'b011);
        cycle(1'b0, 1'b0, 3'b000);
        chk("wr_new", bus.state, 4);
        // Stored out-of-range next forces INIT and flags
        wr_rule(4, 0, 1'b1, 3'b000, 3'b000, 7, 2'b00, 2'b00, 1'b0, 3'b000);
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b0, 1'b0, 3'b000);
        chk("badnext_state", bus.state, 0); chk("badnext_err", bus.cfg_err, 1);
        // Mid-run reset from state 2
        cycle(1'b1, 1'b0, 3'b001);
        cycle(1'b0, 1'b0, 3'b000);
        chk("pre_rst_state", bus.state, 2);
        @(negedge clock);
        set_idle();
        reset_L = 1'b0;
        #3;
        cycle(1'b0, 1'b0, 3'b000);
        chk("mrst_state", bus.state, 0); chk("mrst_out", bus.out, 2'b00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, NI'($urandom));
            chk("mrst_hit", bus.hit, 0);
        end
        // Random traffic checked only by the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clock);
            set_idle();
            bus.en = ($urandom_range(0, 3) != 0);
            bus.restart = ($urandom_range(0, 15) == 0);
            bus.in = NI'($urandom);
            r = $urandom_range(0, 9);
            bus.cfg_state = SW'($urandom_range(0, 7));
            bus.cfg_slot = KW'($urandom);
            bus.cfg_valid = ($urandom_range(0, 3) != 0);
            bus.cfg_care = NI'($urandom);
            bus.cfg_match = NI'($urandom);
            bus.cfg_next = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(6, 7)) : SW'($urandom_range(0, 5));
            bus.cfg_omask = NO'($urandom);
            bus.cfg_oval = NO'($urandom);
            bus.cfg_rule_we = (r < 3) || (r == 4);
            bus.cfg_moore_we = (r == 3) || (r == 4);
            if ($urandom_range(0, 499) == 0) reset_L = 1'b0;
        end
        repeat (2) @(negedge clock);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_fsm_engine.md
Name: prog_fsm_engine

Overview:
- Table-driven, run-time programmable FSM engine. It is the parametrised successor to fixed, hand-declared FSMs: the state count, input/output widths and transitions per state are all parameters.
- The transition table, Moore outputs and Mealy overrides are loaded through a config port, so the same hardware can run any FSM described in the team's FSM HDL.
- Sits between a control block that owns the config port and datapath logic driven by `out`.

Parameters:
- N_STATES, 8, number of states; state index width SW = max(1, $clog2(N_STATES)).
- N_IN, 3, width of condition input vector `in`.
- N_OUT, 2, width of output vector `out`.
- N_SLOTS, 4, transition rules per state; slot index width KW = max(1, $clog2(N_SLOTS)).
- INIT_STATE, 0, state entered on reset and on `restart`; must be < N_STATES.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_L  in  1  synchronous active-low reset.
- en  in  1  advance enable; when 0 the state holds and Mealy overrides are suppressed.
- restart  in  1  synchronous return to INIT_STATE; the table is kept.
- in  in  N_IN  condition inputs.
- cfg_rule_we  in  1  write one transition rule.
- cfg_moore_we  in  1  write one Moore output entry.
- cfg_state  in  SW  target state of the config write.
- cfg_slot  in  KW  target slot (rule writes only).
- cfg_valid  in  1  rule enable bit.
- cfg_care  in  N_IN  rule input care mask.
- cfg_match  in  N_IN  rule input match value.
- cfg_next  in  SW  rule next state.
- cfg_omask  in  N_OUT  Mealy override mask (rule) / unused (Moore).
- cfg_oval  in  N_OUT  Mealy override values (rule) / Moore output value.
- state  out  SW  current state register.
- out  out  N_OUT  combinational output.
- hit  out  1  a rule matched this cycle.
- hit_slot  out  KW  index of the matching rule (0 when hit=0).
- cfg_err  out  1  registered; pulses 1 cycle after a write with out-of-range cfg_state or cfg_slot.

Behaviour:
- Reset (reset_L=0 at posedge):
  - state=INIT_STATE.
  - All rule valid bits = 0; all Moore entries = 0.
  - cfg_err=0.
  - Consequently out=0 and hit=0.
- Rule r of the current state matches when valid & ((in ^ match) & care) == 0.
- Care = 0 is an unconditional rule, equivalent to a `1` condition.
- Priority: the lowest-index matching slot wins; hit_slot is that index.
- Next state at posedge, in this order of precedence:
  - reset;
  - restart → INIT_STATE;
  - en & hit → winning rule's next;
  - otherwise hold.
- A self-loop rule (next == state) is a legal hit.
- Output (combinational, same cycle):
  - out = moore[state].
  - When en & hit, each bit set in the winner's omask is replaced by the winner's oval bit.
  - restart does not suppress the override.
- Config writes:
  - Take effect at posedge and are visible to matching on the following cycle. The rule used in the write cycle is the old entry.
  - A simultaneous rule write and Moore write to the same state are both performed.
  - A write with cfg_state ≥ N_STATES, or a rule write with cfg_slot ≥ N_SLOTS, is dropped and sets cfg_err the next cycle.
  - Writes are accepted during reset release and while en=0.
- cfg_next ≥ N_STATES is stored as written. If selected, the next state is forced to INIT_STATE instead, and cfg_err pulses the next cycle.
- Reset asserted mid-operation clears the table as well. The controller must reprogram after reset.
- `in` is assumed stable before posedge; no internal synchronisers.

Test Plan:
- Reset, then one idle cycle → state=0, out=2'b00, hit=0, cfg_err=0.
- Program state0 rule slots:
  - slot0: care=3'b011, match=3'b011, next=1.
  - slot1: care=3'b011, match=3'b001, next=2.
  - Stimulus: en=1, in=3'b011 → hit=1, hit_slot=0, state=1 next cycle.
  - Repeat from state0 with in=3'b001 → state=2.
- Priority: state0 slot0 care=0 next=3 and slot2 care=0 next=5 → hit_slot=0, state=3.
  - Invalidate slot0 → hit_slot=2, state=5.
- Moore/Mealy:
  - moore[1]=2'b10; rule on state1 with omask=2'b01, oval=2'b01, matching in=3'b100.
  - in=3'b100 → out=2'b11. in=3'b000 → out=2'b10, hit=0.
  - en=0 with in=3'b100 → out=2'b10 and state unchanged.
- Boundaries:
  - With N_STATES=6, write cfg_state=7 → cfg_err=1 for exactly one cycle; the table is unchanged.
  - restart and a hit in the same cycle → state=INIT_STATE.
  - Rule write to the active slot in the same cycle it matches → the old next state is used.
- Mid-run reset: reset_L=0 for one cycle while in state 2 → state=0, out=0, all subsequent in values give hit=0.
